// File: rtl/bias_act_accum_pkg.sv
// Shared sizing, state encoding and lane helpers for the bias/activation accumulator.
// Build option: RELU_ACT_EN selects ReLU activation (identity when undefined).
package bias_act_accum_pkg;

  localparam int N_ADDER_TREE = 16;
  localparam int DW           = 18;
  localparam int ACC_GUARD    = 6;
  localparam int ACC_W        = DW + ACC_GUARD;
  localparam int SHIFT        = 0;
  localparam int BUS_W        = N_ADDER_TREE * DW;

  typedef enum logic {
    ACC  = 1'b0,
    FULL = 1'b1
  } state_t;

  // Extract lane idx from a packed lane vector (lane i lives at [DW*(i+1)-1:DW*i]).
  function automatic logic signed [DW-1:0] lane_slice(input logic [BUS_W-1:0] vec,
                                                      input int unsigned idx);
    return vec[idx*DW +: DW];
  endfunction

endpackage

// File: rtl/bias_act_accum_if.sv
// Partial-sum input stream and activated-result output stream of one layer.
interface bias_act_accum_if;
  import bias_act_accum_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [BUS_W-1:0] out_data;

  // Upstream adder trees and downstream consumer side.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Accumulator side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/bias_act_accum_lane.sv
// Single-lane datapath: saturating accumulate, bias add, half-up rounding shift,
// activation and saturation to DW bits.
// Build option: RELU_ACT_EN selects ReLU activation (identity when undefined).
module bias_act_lane
  import bias_act_accum_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 acc_en,
  input  logic                 load_en,
  input  logic                 first,
  input  logic signed [DW-1:0] part,
  input  logic signed [DW-1:0] bias,
  output logic signed [DW-1:0] result,
  output logic                 acc_sat,
  output logic                 out_sat
);

  localparam logic signed [ACC_W:0]   ACC_HI = (ACC_W+1)'(2**(ACC_W-1) - 1);
  localparam logic signed [ACC_W:0]   ACC_LO = (ACC_W+1)'(-(2**(ACC_W-1)));
  localparam logic signed [ACC_W+1:0] OUT_HI = (ACC_W+2)'(2**(DW-1) - 1);
  localparam logic signed [ACC_W+1:0] OUT_LO = (ACC_W+2)'(-(2**(DW-1)));

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W:0]   acc_sum;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W:0]   biased;
  logic signed [ACC_W+1:0] rounded;
  logic signed [ACC_W+1:0] activated;
  logic signed [DW-1:0]    out_next;

  // Add the beat to the running sum (restarting on a new pixel), clamping at the accumulator limits.
  always_comb begin
    acc_sat  = 1'b0;
    base     = first ? '0 : acc;
    acc_sum  = {base[ACC_W-1], base} + {{(ACC_W+1-DW){part[DW-1]}}, part};
    acc_next = acc_sum[ACC_W-1:0];
    if (acc_sum > ACC_HI) begin
      acc_next = ACC_HI[ACC_W-1:0];
      acc_sat  = 1'b1;
    end else if (acc_sum < ACC_LO) begin
      acc_next = ACC_LO[ACC_W-1:0];
      acc_sat  = 1'b1;
    end
    biased = {acc_next[ACC_W-1], acc_next} + {{(ACC_W+1-DW){bias[DW-1]}}, bias};
  end

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [ACC_W+1:0] HALF = (ACC_W+2)'(1) <<< (SHIFT - 1);
      logic signed [ACC_W+1:0] pre;
      // Round half-up, then arithmetic shift down.
      always_comb begin
        pre     = {biased[ACC_W], biased} + HALF;
        rounded = pre >>> SHIFT;
      end
    end else begin : g_noround
      assign rounded = {biased[ACC_W], biased};
    end
  endgenerate

  // Apply the activation, then clamp into the signed DW-bit feature-map range.
  always_comb begin
`ifdef RELU_ACT_EN
    activated = rounded[ACC_W+1] ? '0 : rounded;
`else
    activated = rounded;
`endif
    out_sat  = 1'b0;
    out_next = activated[DW-1:0];
    if (activated > OUT_HI) begin
      out_next = OUT_HI[DW-1:0];
      out_sat  = 1'b1;
    end else if (activated < OUT_LO) begin
      out_next = OUT_LO[DW-1:0];
      out_sat  = 1'b1;
    end
  end

  // Accumulator advances on every accepted beat; result register loads on an accepted last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (acc_en)  acc    <= acc_next;
      if (load_en) result <= out_next;
    end
  end

endmodule

// File: rtl/bias_act_accum.sv
// Per-lane partial-sum accumulator with bias, activation and saturation for one
// convolution layer; N_ADDER_TREE lanes share one valid/ready control path.
// Build option: RELU_ACT_EN selects ReLU activation (identity when undefined).
module bias_act_accum
  import bias_act_accum_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BUS_W-1:0] bias,
  bias_act_accum_if.slave  s,
  input  logic             clr_flag,
  output logic             sat_flag,
  output logic [7:0]       pass_cnt
);

  state_t               state, state_next;
  logic                 first;
  logic                 accept;
  logic                 load;
  logic                 any_sat;
  logic [BUS_W-1:0]     out_bus;
  logic signed [DW-1:0] lane_res     [N_ADDER_TREE];
  logic                 lane_acc_sat [N_ADDER_TREE];
  logic                 lane_out_sat [N_ADDER_TREE];

  assign s.out_valid = (state == FULL);
  assign s.in_ready  = !s.out_valid || s.out_ready;
  assign accept      = s.in_valid && s.in_ready;
  assign load        = accept && s.in_last;
  assign s.out_data  = out_bus;

  genvar gi;
  generate
    for (gi = 0; gi < N_ADDER_TREE; gi++) begin : g_lane
      bias_act_lane u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .acc_en  (accept),
        .load_en (load),
        .first   (first),
        .part    (lane_slice(s.in_data, gi)),
        .bias    (lane_slice(bias, gi)),
        .result  (lane_res[gi]),
        .acc_sat (lane_acc_sat[gi]),
        .out_sat (lane_out_sat[gi])
      );
    end
  endgenerate

  // Pack lane results and collect saturation events that count for this cycle.
  always_comb begin
    out_bus = '0;
    any_sat = 1'b0;
    for (int i = 0; i < N_ADDER_TREE; i++) begin
      out_bus[i*DW +: DW] = lane_res[i];
      if (accept && lane_acc_sat[i]) any_sat = 1'b1;
      if (load && lane_out_sat[i])   any_sat = 1'b1;
    end
  end

  // State register: FULL while a result waits for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_next;
  end

  // A new result keeps FULL even when the old one leaves this cycle.
  always_comb begin
    state_next = state;
    case (state)
      ACC:     if (load) state_next = FULL;
      FULL:    if (load) state_next = FULL;
               else if (s.out_ready) state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  // Pixel bookkeeping: first-beat marker and saturating beat count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first    <= 1'b1;
      pass_cnt <= 8'd0;
    end else if (accept) begin
      first <= s.in_last;
      if (first)                 pass_cnt <= 8'd1;
      else if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
    end
  end

  // Sticky saturation flag; a clear wins over a same-cycle event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sat_flag <= 1'b0;
    else if (clr_flag) sat_flag <= 1'b0;
    else if (any_sat)  sat_flag <= 1'b1;
  end

endmodule

// File: tb/tb_bias_act_accum.sv
// Testbench for bias_act_accum; honours RELU_ACT_EN when defined for the build.
module tb_bias_act_accum;
  import bias_act_accum_pkg::*;

  localparam int    LW      = BUS_W;
  localparam longint ACC_MAXV = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint ACC_MINV = -(longint'(1) <<< (ACC_W-1));
  localparam longint OUT_MAXV = (longint'(1) <<< (DW-1)) - 1;
  localparam longint OUT_MINV = -(longint'(1) <<< (DW-1));

  logic          clk = 1'b0;
  logic          rst_n;
  logic [LW-1:0] bias;
  logic          clr_flag;
  logic          sat_flag;
  logic [7:0]    pass_cnt;

  bias_act_accum_if bus();

  bias_act_accum dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bias     (bias),
    .s        (bus.slave),
    .clr_flag (clr_flag),
    .sat_flag (sat_flag),
    .pass_cnt (pass_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint mAcc [N_ADDER_TREE];
  longint mOut [N_ADDER_TREE];
  bit     mFirst, mOutValid, mSat;
  int     mPass;

  function automatic longint laneOf(input logic [LW-1:0] v, input int i);
    logic signed [DW-1:0] x;
    x = v[i*DW +: DW];
    return longint'(x);
  endfunction

  function automatic logic [LW-1:0] mkLane0(input longint v);
    logic [LW-1:0] r;
    r = '0;
    r[DW-1:0] = v[DW-1:0];
    return r;
  endfunction

  function automatic logic [LW-1:0] rndVec();
    logic [LW-1:0] r;
    longint x;
    r = '0;
    for (int i = 0; i < N_ADDER_TREE; i++) begin
      if ($urandom % 4 == 0) x = longint'($urandom);
      else                   x = longint'($urandom_range(0, 1023)) - 512;
      r[i*DW +: DW] = x[DW-1:0];
    end
    return r;
  endfunction

  function automatic longint floorDiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [LW-1:0] modelOut();
    logic [LW-1:0] r;
    longint t;
    r = '0;
    for (int i = 0; i < N_ADDER_TREE; i++) begin
      t = mOut[i];
      r[i*DW +: DW] = t[DW-1:0];
    end
    return r;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N_ADDER_TREE; i++) begin
      mAcc[i] = 0;
      mOut[i] = 0;
    end
    mFirst    = 1'b1;
    mOutValid = 1'b0;
    mSat      = 1'b0;
    mPass     = 0;
  endtask

  task automatic modelEdge(input bit v, input bit l, input logic [LW-1:0] d,
                           input bit rdy, input bit clr);
    bit     acc;
    bit     satEv;
    longint s;
    longint scale;
    acc   = v && (!mOutValid || rdy);
    satEv = 1'b0;
    scale = longint'(1) <<< SHIFT;
    if (acc) begin
      for (int i = 0; i < N_ADDER_TREE; i++) begin
        s = (mFirst ? 0 : mAcc[i]) + laneOf(d, i);
        if (s > ACC_MAXV)      begin s = ACC_MAXV; satEv = 1'b1; end
        else if (s < ACC_MINV) begin s = ACC_MINV; satEv = 1'b1; end
        mAcc[i] = s;
        if (l) begin
          s = floorDiv(s + laneOf(bias, i) + scale / 2, scale);
`ifdef RELU_ACT_EN
          if (s < 0) s = 0;
`endif
          if (s > OUT_MAXV)      begin s = OUT_MAXV; satEv = 1'b1; end
          else if (s < OUT_MINV) begin s = OUT_MINV; satEv = 1'b1; end
          mOut[i] = s;
        end
      end
      mPass  = mFirst ? 1 : ((mPass == 255) ? 255 : mPass + 1);
      mFirst = l;
    end
    if (acc && l)               mOutValid = 1'b1;
    else if (mOutValid && rdy)  mOutValid = 1'b0;
    if (clr)        mSat = 1'b0;
    else if (satEv) mSat = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkInt(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk("out_valid", LW'(bus.out_valid), LW'(mOutValid));
    chk("in_ready",  LW'(bus.in_ready),  LW'(!mOutValid || bus.out_ready));
    chk("pass_cnt",  LW'(pass_cnt),      LW'(mPass));
    chk("sat_flag",  LW'(sat_flag),      LW'(mSat));
    chk("out_data",  bus.out_data,       modelOut());
  endtask

  task automatic applyStimulus(input bit v, input bit l, input logic [LW-1:0] d,
                               input bit rdy, input bit clr);
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.in_data   = d;
    bus.out_ready = rdy;
    clr_flag      = clr;
    modelEdge(v, l, d, rdy, clr);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #2;
    modelReset();
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    clr_flag      = 1'b0;
    bias          = '0;
    doReset();

    // Single pass with bias.
    bias = mkLane0(-20);
    applyStimulus(1, 1, mkLane0(100), 1, 0);
    chkInt("t1_lane0", laneOf(bus.out_data, 0), 80);
    chkInt("t1_pass", longint'(pass_cnt), 1);
    chkInt("t1_valid", longint'(bus.out_valid), 1);
    bias = '0;
    applyStimulus(0, 0, '0, 1, 0);

    // Three passes, negative sum.
    applyStimulus(1, 0, mkLane0(1000), 1, 0);
    applyStimulus(1, 0, mkLane0(-3000), 1, 0);
    applyStimulus(1, 1, mkLane0(500), 1, 0);
`ifdef RELU_ACT_EN
    chkInt("t2_lane0", laneOf(bus.out_data, 0), 0);
`else
    chkInt("t2_lane0", laneOf(bus.out_data, 0), -1500);
`endif
    chkInt("t2_pass", longint'(pass_cnt), 3);
    applyStimulus(0, 0, '0, 1, 0);

    // Output saturation, sticky flag, clear.
    for (int k = 0; k < 4; k++) applyStimulus(1, k == 3, mkLane0(131071), 1, 0);
    chkInt("t3_lane0", laneOf(bus.out_data, 0), 131071);
    chkInt("t3_sat", longint'(sat_flag), 1);
    applyStimulus(0, 0, '0, 1, 1);
    chkInt("t3_clr", longint'(sat_flag), 0);
    bias = mkLane0(131071);
    applyStimulus(1, 1, mkLane0(131071), 1, 1);
    chkInt("t3_clr_prio", longint'(sat_flag), 0);
    bias = '0;
    applyStimulus(0, 0, '0, 1, 0);

    // Backpressure: held result, stalled beats.
    applyStimulus(1, 1, mkLane0(7), 0, 0);
    applyStimulus(1, 0, mkLane0(3), 0, 0);
    chkInt("t4_nolast_stall", longint'(pass_cnt), 1);
    applyStimulus(1, 1, mkLane0(9), 0, 0);
    chkInt("t4_hold_lane0", laneOf(bus.out_data, 0), 7);
    chkInt("t4_hold_valid", longint'(bus.out_valid), 1);
    applyStimulus(1, 0, mkLane0(3), 1, 0);
    applyStimulus(1, 1, mkLane0(5), 1, 0);
    chkInt("t4_next_lane0", laneOf(bus.out_data, 0), 8);
    chkInt("t4_next_pass", longint'(pass_cnt), 2);

    // Back-to-back single-pass pixels.
    for (int k = 0; k < 6; k++) begin
      bias = rndVec();
      applyStimulus(1, 1, rndVec(), 1, 0);
      chkInt("t5_valid", longint'(bus.out_valid), 1);
    end
    applyStimulus(0, 0, '0, 1, 1);

    // Reset mid-pixel.
    applyStimulus(1, 0, mkLane0(1000), 1, 0);
    applyStimulus(1, 0, mkLane0(1000), 1, 0);
    doReset();
    chkInt("t6_rst_pass", longint'(pass_cnt), 0);
    bias = '0;
    for (int k = 0; k < 4; k++) applyStimulus(1, k == 3, mkLane0(10 * (k + 1)), 1, 0);
    chkInt("t6_lane0", laneOf(bus.out_data, 0), 100);
    chkInt("t6_pass", longint'(pass_cnt), 4);

    // Long pixel: accumulator clamp and pass counter ceiling.
    bias = {N_ADDER_TREE{mkLane0(-131072)}};
    for (int k = 0; k < 260; k++)
      applyStimulus(1, k == 259, {N_ADDER_TREE{mkLane0(-131072)}}, 1, 0);
    chkInt("t7_pass", longint'(pass_cnt), 255);
    chkInt("t7_sat", longint'(sat_flag), 1);
`ifdef RELU_ACT_EN
    chkInt("t7_lane0", laneOf(bus.out_data, 0), 0);
`else
    chkInt("t7_lane0", laneOf(bus.out_data, 0), -131072);
`endif
    applyStimulus(0, 0, '0, 1, 1);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      bias = rndVec();
      applyStimulus($urandom % 4 != 0, $urandom % 3 == 0, rndVec(),
                    $urandom % 4 != 0, $urandom % 16 == 0);
    end

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
